// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC trig accelerator.
// Angles are signed Q4.28 radians throughout.
package cordic_pkg;

  localparam int W      = 32;
  localparam int ITER   = 3;
  localparam int Q_FRAC = 28;

  localparam logic [31:0] HALF_PI    = 32'h1921FB54;
  localparam logic [31:0] QUARTER_PI = 32'h0C90FDAA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_angle_reducer_if.sv
// Request/result handshake between the register block, the angle reducer and the CORDIC core.
interface cordic_angle_reducer_if #(
  parameter int W = cordic_pkg::W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_angle;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_angle;
  logic [1:0]   out_quadrant;

  modport master (
    output in_valid, in_angle, out_ready,
    input  in_ready, out_valid, out_angle, out_quadrant
  );

  modport slave (
    input  in_valid, in_angle, out_ready,
    output in_ready, out_valid, out_angle, out_quadrant
  );

endinterface

// File: rtl/cordic_angle_reducer.sv
// Reduces a Q4.28 angle modulo pi/2 into a residual in (-pi/4, +pi/4] and a quadrant,
// using an iterative restoring division by pi/2 followed by a one-cycle fold.
module cordic_angle_reducer
  import cordic_pkg::*;
#(
  parameter int W    = cordic_pkg::W,
  parameter int ITER = cordic_pkg::ITER
) (
  input  logic                   clk,
  input  logic                   reset,
  cordic_angle_reducer_if.slave  io,
  output logic                   busy
);

  localparam int K_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [W+ITER-1:0] HP_EXT = (W+ITER)'(HALF_PI);
  localparam logic [W-1:0]      QP     = W'(QUARTER_PI);

  function automatic logic signed [W-1:0] cond_negate(input logic n, input logic signed [W-1:0] x);
    return n ? -x : x;
  endfunction

  function automatic logic [1:0] cond_negate_q(input logic n, input logic [1:0] x);
    return n ? 2'(-x) : x;
  endfunction

  state_t state, next_state;

  logic [K_W-1:0]        k;
  logic [W-1:0]          mag;
  logic [1:0]            q;
  logic                  neg;
  logic                  accept;

  logic [W+ITER-1:0]     sub_op;
  logic [W-1:0]          diff;
  logic                  fits;
  logic                  fold;
  logic signed [W-1:0]   r_fix;
  logic signed [W-1:0]   r_fin;
  logic [1:0]            q_fin;

  logic signed [W-1:0]   out_angle_q;
  logic [1:0]            out_quadrant_q;

  assign io.in_ready     = (state == IDLE) || ((state == OUT) && io.out_ready);
  assign accept          = io.in_valid && io.in_ready;
  assign io.out_valid    = (state == OUT);
  assign io.out_angle    = out_angle_q;
  assign io.out_quadrant = out_quadrant_q;
  assign busy            = (state != IDLE);

  // One comparator/subtractor serves both the DIV steps (pi/2 << k) and the FIX fold (pi/2).
  always_comb begin
    sub_op = (state == DIV) ? (HP_EXT << k) : HP_EXT;
    fits   = ({{ITER{1'b0}}, mag} >= sub_op);
    diff   = mag - sub_op[W-1:0];
    fold   = (mag > QP);
    r_fix  = fold ? $signed(diff) : $signed(mag);
    r_fin  = cond_negate(neg, r_fix);
    q_fin  = cond_negate_q(neg, q + {1'b0, fold});
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DIV;
      DIV:     if (k == '0) next_state = FIX;
      FIX:     next_state = OUT;
      OUT:     if (io.out_ready) next_state = accept ? DIV : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      k              <= '0;
      out_angle_q    <= '0;
      out_quadrant_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        k <= K_W'(ITER - 1);
      end else if ((state == DIV) && (k != '0)) begin
        k <= k - 1'b1;
      end
      if (state == FIX) begin
        out_angle_q    <= r_fin;
        out_quadrant_q <= q_fin;
      end
    end
  end

  // Operand datapath; only quotient bits below 2 matter for the quadrant, so q accumulates mod 4.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg <= io.in_angle[W-1];
      mag <= io.in_angle[W-1] ? (W'(0) - io.in_angle) : io.in_angle;
      q   <= '0;
    end else if ((state == DIV) && fits) begin
      mag <= diff;
      q   <= q + 2'(32'd1 << k);
    end
  end

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed bench for cordic_angle_reducer: hand-computed vectors, backpressure and async reset.
module tb_cordic_angle_reducer;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  cordic_angle_reducer_if #(.W(32)) bus ();

  cordic_angle_reducer dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, returning the number of edges seen (capped).
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_angle(input string tag, input logic [31:0] angle,
                           input logic [1:0] exp_q, input logic [31:0] exp_a);
    int n;
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      step();
      w++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_angle = angle;
    step();
    bus.in_valid = 1'b0;
    bus.in_angle = 32'hDEADBEEF;
    wait_valid(n);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_angle"}, bus.out_angle, exp_a);
    check({tag, "_quad"}, 32'(bus.out_quadrant), 32'(exp_q));
    step();
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] held_a;
    logic [1:0]  held_q;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_angle = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_angle", bus.out_angle, 32'd0);
    check("rst_out_quad",  32'(bus.out_quadrant), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_angle("zero",     32'h00000000, 2'd0, 32'h00000000);
    run_angle("two",      32'h20000000, 2'd1, 32'h06DE04AC);
    run_angle("one",      32'h10000000, 2'd1, 32'hF6DE04AC);
    run_angle("neg_one",  32'hF0000000, 2'd3, 32'h0921FB54);
    run_angle("neg_eight",32'h80000000, 2'd3, 32'hFDA9E8A4);
    run_angle("qpi_edge", 32'h0C90FDAA, 2'd0, 32'h0C90FDAA);
    run_angle("qpi_over", 32'h0C90FDAB, 2'd1, 32'hF36F0257);

    // Backpressure: hold the result while a competing request is presented.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_angle  = 32'h20000000;
    step();
    bus.in_angle  = 32'h10000000;
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd4);
    held_a = bus.out_angle;
    held_q = bus.out_quadrant;
    check("bp_angle", held_a, 32'h06DE04AC);
    check("bp_quad",  32'(held_q), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_angle", bus.out_angle, 32'h06DE04AC);
      check("bp_hold_quad",  32'(bus.out_quadrant), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    bus.in_angle  = 32'hF0000000;
    #1;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_out_valid_low", 32'(bus.out_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_valid(n);
    check("b2b_latency", 32'(n), 32'd4);
    check("b2b_angle", bus.out_angle, 32'h0921FB54);
    check("b2b_quad",  32'(bus.out_quadrant), 32'd3);
    step();

    // Asynchronous reset in the middle of DIV.
    bus.in_valid = 1'b1;
    bus.in_angle = 32'h10000000;
    step();
    bus.in_valid = 1'b0;
    step();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_angle", bus.out_angle, 32'd0);
    check("arst_out_quad",  32'(bus.out_quadrant), 32'd0);
    check("arst_busy",      32'(busy), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("after_rst_in_ready",  32'(bus.in_ready), 32'd1);
      check("after_rst_out_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    run_angle("post_rst_two", 32'h20000000, 2'd1, 32'h06DE04AC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
